// File: rtl/w_bus_if.sv
// w_bus_if: W-bus arbiter signal bundle.
//   master: drives src_en/src_data/rr_mode/hold_en/clr_err and observes the bus outputs.
//   slave : the arbiter side; consumes the source requests and drives w_bus, grant and the contention flags.
interface w_bus_if #(
  parameter int WIDTH = 8,
  parameter int SOURCES = 5,
  parameter int CNT_W = 8
);
  logic [SOURCES-1:0]       src_en;
  logic [SOURCES*WIDTH-1:0] src_data;
  logic                     rr_mode;
  logic                     hold_en;
  logic                     clr_err;
  logic [WIDTH-1:0]         w_bus;
  logic                     bus_valid;
  logic [SOURCES-1:0]       grant;
  logic                     contention;
  logic                     contention_sticky;
  logic [CNT_W-1:0]         contention_cnt;
  modport master (
    output src_en, src_data, rr_mode, hold_en, clr_err,
    input  w_bus, bus_valid, grant, contention, contention_sticky, contention_cnt
  );
  modport slave (
    input  src_en, src_data, rr_mode, hold_en, clr_err,
    output w_bus, bus_valid, grant, contention, contention_sticky, contention_cnt
  );
endinterface

// File: rtl/w_bus_ctrl.sv
// w_bus_ctrl: registered W-bus arbiter (fixed priority or round robin) with bus-holder and contention counting.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset.
//   bus (slave)    : per-source enables/data and mode controls in; registered w_bus, one-hot grant,
//                    bus_valid and contention pulse/sticky/saturating counter out.
module w_bus_ctrl #(
  parameter int WIDTH = 8,
  parameter int SOURCES = 5,
  parameter logic [SOURCES-1:0] EN_POL = SOURCES'(5'b11001),
  parameter int CNT_W = 8
) (
  input logic   clock,
  input logic   reset_n,
  w_bus_if.slave bus
);
  localparam int IDX_W = $clog2(SOURCES);
  logic [SOURCES-1:0] req;
  logic               any_req;
  logic               multi_req;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   fp_idx;
  logic [IDX_W-1:0]   rr_idx;
  logic [IDX_W-1:0]   win;
  logic [WIDTH-1:0]   sel_data;
  // rr_ptr + k never reaches 2*SOURCES, so one conditional subtract is a full modulo
  function automatic logic [IDX_W-1:0] wrap(input int v);
    return IDX_W'(v >= SOURCES ? v - SOURCES : v);
  endfunction
  assign req       = ~(bus.src_en ^ EN_POL);
  assign any_req   = |req;
  // clearing the lowest set bit leaves something only if two or more were set
  assign multi_req = |(req & (req - SOURCES'(1)));
  assign win       = bus.rr_mode ? rr_idx : fp_idx;
  // descending loops so the last hit (lowest index / nearest to rr_ptr+1) wins
  always_comb begin
    fp_idx = '0;
    rr_idx = '0;
    for (int i = SOURCES - 1; i >= 0; i--)
      if (req[i]) fp_idx = IDX_W'(i);
    for (int k = SOURCES; k >= 1; k--)
      if (req[wrap(int'(rr_ptr) + k)]) rr_idx = wrap(int'(rr_ptr) + k);
  end
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < SOURCES; i++)
      if (win == IDX_W'(i)) sel_data = bus.src_data[i*WIDTH +: WIDTH];
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.w_bus             <= '0;
      bus.grant             <= '0;
      bus.bus_valid         <= 1'b0;
      bus.contention        <= 1'b0;
      bus.contention_sticky <= 1'b0;
      bus.contention_cnt    <= '0;
      rr_ptr                <= IDX_W'(SOURCES - 1);
    end else begin
      bus.w_bus             <= any_req ? sel_data : bus.hold_en ? bus.w_bus : '0;
      bus.grant             <= any_req ? SOURCES'(1) << win : '0;
      bus.bus_valid         <= any_req;
      bus.contention        <= multi_req;
      bus.contention_sticky <= bus.clr_err ? 1'b0 : bus.contention_sticky | multi_req;
      bus.contention_cnt    <= bus.clr_err ? '0 :
                               (multi_req && bus.contention_cnt != '1) ? bus.contention_cnt + CNT_W'(1) :
                               bus.contention_cnt;
      rr_ptr                <= any_req ? win : rr_ptr;
    end
  end
endmodule

// File: tb/tb_w_bus_ctrl.sv
// tb_w_bus_ctrl: scoreboard bench; directed steps push hand-computed expectations, a monitor pops and compares.
module tb_w_bus_ctrl;
  typedef struct {
    logic [7:0] w;
    logic [4:0] g;
    logic       v;
    logic       c;
    logic       s;
    logic [7:0] n;
    logic [1:0] n2;
  } exp_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  w_bus_if #(.WIDTH(8), .SOURCES(5), .CNT_W(8)) b ();
  w_bus_if #(.WIDTH(8), .SOURCES(5), .CNT_W(2)) b2 ();
  w_bus_ctrl #(.WIDTH(8), .SOURCES(5), .EN_POL(5'b11001), .CNT_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .bus(b.slave));
  w_bus_ctrl #(.WIDTH(8), .SOURCES(5), .EN_POL(5'b11001), .CNT_W(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .bus(b2.slave));
  assign b2.src_en   = b.src_en;
  assign b2.src_data = b.src_data;
  assign b2.rr_mode  = b.rr_mode;
  assign b2.hold_en  = b.hold_en;
  assign b2.clr_err  = b.clr_err;
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // called at a negedge; drives inputs for the next rising edge and ends on the following negedge
  task automatic step(input logic [4:0] en, input logic rr, input logic hold, input logic clr,
                      input logic [7:0] w, input logic [4:0] g, input logic v, input logic c,
                      input logic s, input logic [7:0] n, input logic [1:0] n2);
    b.src_en  = en;
    b.rr_mode = rr;
    b.hold_en = hold;
    b.clr_err = clr;
    sb.push_back('{w, g, v, c, s, n, n2});
    @(negedge clock);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, ".w_bus"}, 32'(b.w_bus), 0);
    chk({tag, ".grant"}, 32'(b.grant), 0);
    chk({tag, ".bus_valid"}, 32'(b.bus_valid), 0);
    chk({tag, ".contention"}, 32'(b.contention), 0);
    chk({tag, ".sticky"}, 32'(b.contention_sticky), 0);
    chk({tag, ".cnt"}, 32'(b.contention_cnt), 0);
    chk({tag, ".cnt2"}, 32'(b2.contention_cnt), 0);
  endtask
  always begin
    @(posedge clock);
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("w_bus", 32'(b.w_bus), 32'(e.w));
      chk("grant", 32'(b.grant), 32'(e.g));
      chk("bus_valid", 32'(b.bus_valid), 32'(e.v));
      chk("contention", 32'(b.contention), 32'(e.c));
      chk("sticky", 32'(b.contention_sticky), 32'(e.s));
      chk("cnt", 32'(b.contention_cnt), 32'(e.n));
      chk("cnt2", 32'(b2.contention_cnt), 32'(e.n2));
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  // enable encodings (EN_POL 11001, idle = 00110):
  //   src0 00111  src4 10110  src3 01110  src0+3 01111  src0+1 00101  all 11001
  initial begin
    b.src_en   = 5'b00110;
    b.src_data = 40'h44_5C_22_11_0A;
    b.rr_mode  = 1'b0;
    b.hold_en  = 1'b1;
    b.clr_err  = 1'b0;
    #1;
    chk_reset("por");
    @(negedge clock);
    reset_n = 1'b1;
    //    en        rr    hold  clr   w      g         v     c     s     n     n2
    step(5'b00111, 1'b0, 1'b1, 1'b0, 8'h0A, 5'b00001, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0);
    step(5'b01111, 1'b0, 1'b1, 1'b0, 8'h0A, 5'b00001, 1'b1, 1'b1, 1'b1, 8'd1, 2'd1);
    step(5'b00111, 1'b0, 1'b1, 1'b1, 8'h0A, 5'b00001, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0);
    step(5'b01111, 1'b0, 1'b1, 1'b1, 8'h0A, 5'b00001, 1'b1, 1'b1, 1'b0, 8'd0, 2'd0);
    step(5'b10110, 1'b0, 1'b1, 1'b0, 8'h44, 5'b10000, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0);
    step(5'b11001, 1'b1, 1'b1, 1'b0, 8'h0A, 5'b00001, 1'b1, 1'b1, 1'b1, 8'd1, 2'd1);
    step(5'b11001, 1'b1, 1'b1, 1'b0, 8'h11, 5'b00010, 1'b1, 1'b1, 1'b1, 8'd2, 2'd2);
    step(5'b11001, 1'b1, 1'b1, 1'b0, 8'h22, 5'b00100, 1'b1, 1'b1, 1'b1, 8'd3, 2'd3);
    step(5'b11001, 1'b1, 1'b1, 1'b0, 8'h5C, 5'b01000, 1'b1, 1'b1, 1'b1, 8'd4, 2'd3);
    step(5'b11001, 1'b1, 1'b1, 1'b0, 8'h44, 5'b10000, 1'b1, 1'b1, 1'b1, 8'd5, 2'd3);
    step(5'b11001, 1'b1, 1'b1, 1'b0, 8'h0A, 5'b00001, 1'b1, 1'b1, 1'b1, 8'd6, 2'd3);
    step(5'b11001, 1'b1, 1'b1, 1'b0, 8'h11, 5'b00010, 1'b1, 1'b1, 1'b1, 8'd7, 2'd3);
    step(5'b01110, 1'b0, 1'b1, 1'b0, 8'h5C, 5'b01000, 1'b1, 1'b0, 1'b1, 8'd7, 2'd3);
    step(5'b00110, 1'b0, 1'b1, 1'b0, 8'h5C, 5'b00000, 1'b0, 1'b0, 1'b1, 8'd7, 2'd3);
    step(5'b00110, 1'b0, 1'b1, 1'b0, 8'h5C, 5'b00000, 1'b0, 1'b0, 1'b1, 8'd7, 2'd3);
    step(5'b00110, 1'b0, 1'b0, 1'b0, 8'h00, 5'b00000, 1'b0, 1'b0, 1'b1, 8'd7, 2'd3);
    step(5'b01111, 1'b1, 1'b1, 1'b0, 8'h0A, 5'b00001, 1'b1, 1'b1, 1'b1, 8'd8, 2'd3);
    step(5'b01111, 1'b1, 1'b1, 1'b0, 8'h5C, 5'b01000, 1'b1, 1'b1, 1'b1, 8'd9, 2'd3);
    step(5'b01111, 1'b0, 1'b1, 1'b0, 8'h0A, 5'b00001, 1'b1, 1'b1, 1'b1, 8'd10, 2'd3);
    step(5'b00110, 1'b0, 1'b1, 1'b1, 8'h0A, 5'b00000, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    step(5'b00101, 1'b1, 1'b1, 1'b0, 8'h11, 5'b00010, 1'b1, 1'b1, 1'b1, 8'd1, 2'd1);
    step(5'b11001, 1'b1, 1'b1, 1'b0, 8'h22, 5'b00100, 1'b1, 1'b1, 1'b1, 8'd2, 2'd2);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk_reset("midrst");
    @(negedge clock);
    reset_n = 1'b1;
    step(5'b11001, 1'b1, 1'b1, 1'b0, 8'h0A, 5'b00001, 1'b1, 1'b1, 1'b1, 8'd1, 2'd1);
    step(5'b11001, 1'b1, 1'b1, 1'b0, 8'h11, 5'b00010, 1'b1, 1'b1, 1'b1, 8'd2, 2'd2);
    begin
      int waits = 0;
      while (sb.size() != 0 && waits < 10) begin
        @(negedge clock);
        waits++;
      end
    end
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
